// File: rtl/seq_add_arbiter_pkg.sv
// Shared types and sizing helpers for the byte-serial add/subtract arbiter.
package seq_add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  // Number of byte slices needed for a given operand width.
  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

  // Width of the slice counter (at least one bit).
  function automatic int cnt_width(input int width);
    int n;
    n = slice_count(width);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_CLA.sv
// 8-bit carry-lookahead adder slice with carry-in, carry-out and signed overflow.
module eight_bit_CLA (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout,
  output logic       overflow
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prod;

  // Expand every carry as a flat sum of generate terms gated by propagate chains.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    prod = 1'b0;
    c[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & Cin);
    end
  end

  assign S        = p ^ c[7:0];
  assign Cout     = c[8];
  assign overflow = c[8] ^ c[7];

endmodule

// File: rtl/seq_add_arbiter.sv
// Two-requester round-robin front end feeding one shared 8-bit CLA slice that
// computes a WIDTH-bit add/subtract one byte per cycle.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. reqN_ready is only high in IDLE for the granted requester and
// does not depend on anything the requester does after the handshake; rsp_valid
// stays high with rsp_* stable until a cycle where rsp_ready is also high.
module seq_add_arbiter
  import seq_add_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output state_t           dbg_state
);

  localparam int NS    = slice_count(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NS - 1);

  state_t             state_q;
  state_t             state_d;
  logic               grant_valid;
  logic               grant_id;
  logic               accept;
  logic               last_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W+2:0]   lsb;
  logic               last_slice;
  logic [7:0]         slice_a;
  logic [7:0]         slice_b;
  logic [7:0]         slice_s;
  logic               slice_cout;
  logic               slice_ovf;

  assign dbg_state  = state_q;
  assign lsb        = {cnt_q, 3'b000};
  assign last_slice = (cnt_q == LAST_CNT);
  assign slice_a    = a_q[lsb +: SLICE_W];
  assign slice_b    = b_q[lsb +: SLICE_W];
  assign accept     = req0_ready | req1_ready;

  eight_bit_CLA u_slice (
    .A        (slice_a),
    .B        (slice_b),
    .Cin      (carry_q),
    .S        (slice_s),
    .Cout     (slice_cout),
    .overflow (slice_ovf)
  );

  // Round-robin choice: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready to the granted requester in IDLE, response valid in DONE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state_q == IDLE && grant_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    rsp_valid = (state_q == DONE);
  end

  // Operand capture on handshake, then one byte per cycle through the shared slice.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (accept) begin
      a_q     <= grant_id ? req1_a : req0_a;
      b_q     <= grant_id ? (req1_b ^ {WIDTH{req1_sub}}) : (req0_b ^ {WIDTH{req0_sub}});
      carry_q <= grant_id ? req1_sub : req0_sub;
      cnt_q   <= '0;
      rsp_id  <= grant_id;
      last_q  <= grant_id;
    end else if (state_q == RUN) begin
      rsp_sum[lsb +: SLICE_W] <= slice_s;
      carry_q                 <= slice_cout;
      cnt_q                   <= cnt_q + 1'b1;
      if (last_slice) begin
        rsp_cout <= slice_cout;
        rsp_ovf  <= slice_ovf;
      end
    end
  end

endmodule

// File: doc/seq_add_arbiter.md
# seq_add_arbiter

Shares one 8-bit carry-lookahead slice between two requesters to perform WIDTH-bit add/subtract over WIDTH/8 cycles. Sits in the ALU beside the single-cycle adder as a low-area multi-cycle arithmetic unit. Round-robin arbitration on the request side, valid/ready handshake on both sides, byte-serial sequencing of the adder slice.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8, minimum 16
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  operands
- req0_sub  in  1  1 = a - b, 0 = a + b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that issued the result
- rsp_sum  out  WIDTH  result
- rsp_cout  out  1  carry out of MSB (subtract: 1 = no borrow)
- rsp_ovf  out  1  signed overflow

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: grant = requester with valid; if both valid, the one not granted last. Round-robin pointer resets to favour req0.
- reqN_ready = (state == IDLE) & grant == N, combinational; at most one ready high per cycle; both low during reset.
- Handshake (valid & ready): latch a, b XOR {WIDTH{sub}}, carry register <= sub, slice counter <= 0, rsp_id <= N, pointer <= N; go RUN.
- RUN, per cycle k = 0..WIDTH/8-1: adder inputs = a[8k+7:8k], b'[8k+7:8k], carry register; write sum byte k into rsp_sum[8k+7:8k]; carry register <= slice carry out; counter++.
- Last slice (k = WIDTH/8-1): rsp_cout <= slice carry out; rsp_ovf <= slice overflow (carry into bit 7 XOR carry out); go DONE.
- DONE: rsp_valid = 1; rsp_sum/cout/ovf/id held stable until rsp_ready; on rsp_valid & rsp_ready go IDLE.
- Operand inputs sampled only on the handshake cycle; later changes have no effect.
- Requester dropping valid without handshake: no grant, no state change, pointer unchanged.
- Reset mid-RUN or mid-DONE: operation discarded, no response issued, all outputs to reset values.
- Reset values: rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, req*_ready 0 while reset high.

## Timing
- Accept in cycle n; RUN occupies cycles n+1 .. n+WIDTH/8; rsp_valid high from cycle n+WIDTH/8+1 (n+5 for WIDTH=32).
- rsp_ready high in first DONE cycle: IDLE next cycle, next accept earliest same cycle; minimum issue period WIDTH/8+2 (6 for 32).
- rsp_valid stays high, values unchanged, for any number of rsp_ready-low cycles; reqN_ready low throughout RUN and DONE.
- No combinational path from reqN_valid to rsp_*; rsp_* are registered.

## Structure
- Shared package: state enum {IDLE, RUN, DONE}; constant SLICE_W = 8; function computing slice count WIDTH/SLICE_W and counter width.
- One sub-module instance: eight_bit_CLA (A, B, Cin, S, Cout, overflow) as the shared slice; everything else (arbiter, FSM, operand/result registers, byte mux/demux) in this module.

## Test plan
- req0: 0x000000FF + 0x00000001 -> rsp_sum 0x00000100, cout 0, ovf 0, rsp_id 0, rsp_valid exactly 5 cycles after accept.
- req1: 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout 0, ovf 1; 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout 1, ovf 0.
- Subtract: 5 - 7 -> 0xFFFFFFFE, cout 0, ovf 0; 7 - 5 -> 0x00000002, cout 1; 0x80000000 - 1 -> 0x7FFFFFFF, ovf 1.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id alternates; one accept per 6 cycles.
- rsp_ready low 10 cycles in DONE -> rsp_* constant, both req ready low, operand changes ignored; accept resumes the cycle after rsp_ready.
- reset pulsed in 2nd RUN cycle -> rsp_valid never asserted for that op; following req0 op 0x12345678 + 0x11111111 returns 0x23456789.
